// File: rtl/atomrvcore_pkg.sv
// atomRVCORE shared types for the instruction-memory responder.
// Fault codes, the NOP filler word, and fault classification.
package atomrvcore_pkg;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_OOB      = 2'd2
  } fault_t;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  // Misalignment outranks out-of-range.
  function automatic fault_t classify(
    input logic [1:0] lo,
    input logic       oob
  );
    fault_t f;
    if (lo != 2'b00) f = FAULT_MISALIGN;
    else if (oob)    f = FAULT_OOB;
    else             f = FAULT_NONE;
    return f;
  endfunction

endpackage

// File: rtl/atomrvcore_imem_ram.sv
// Single-clock word RAM, synchronous read-first read, no reset.
// Ports: clk_i, rd_en_i/rd_addr_i/rd_data_o, wr_en_i/wr_addr_i/wr_data_i.
module atomrvcore_imem_ram #(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 1024,
  localparam int ADDRW    = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rd_en_i,
  input  logic [ADDRW-1:0]     rd_addr_i,
  output logic [DATAWIDTH-1:0] rd_data_o,
  input  logic                 wr_en_i,
  input  logic [ADDRW-1:0]     wr_addr_i,
  input  logic [DATAWIDTH-1:0] wr_data_i
);

  logic [DATAWIDTH-1:0] mem_q [DEPTH];
  logic [DATAWIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/atomrvcore_imem_resp.sv
// Instruction-memory responder: in-flight read stage + 2-entry FIFO.
// Ports: IFU req/PC/ready, flush, stall, valid/instr/PC/fault, RAM write.
module atomrvcore_imem_resp
  import atomrvcore_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 1024,
  localparam int ADDRW    = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic [DATAWIDTH-1:0] PC_i,
  output logic                 ready_o,
  input  logic                 flush_i,
  input  logic                 stall_i,
  output logic                 valid_o,
  output logic [DATAWIDTH-1:0] instruction_o,
  output logic [DATAWIDTH-1:0] PC_o,
  output fault_t               fault_o,
  input  logic                 wr_en_i,
  input  logic [ADDRW-1:0]     wr_addr_i,
  input  logic [DATAWIDTH-1:0] wr_data_i
);

  localparam logic [DATAWIDTH-1:0] NOP_W = DATAWIDTH'(RV_NOP);

  typedef struct packed {
    logic [DATAWIDTH-1:0] ins;
    logic [DATAWIDTH-1:0] pc;
    fault_t               flt;
  } ent_t;

  ent_t [1:0] fifo_q, fifo_d;
  ent_t       push_ent;

  logic                 head_q, head_d;
  logic                 tail_q, tail_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 infl_q, infl_d;
  logic [DATAWIDTH-1:0] ipc_q, ipc_d;
  fault_t               iflt_q, iflt_d;

  logic [DATAWIDTH-1:0] rd_data;
  logic                 pop;
  logic                 acc;
  logic                 oob;
  fault_t               acc_flt;

  atomrvcore_imem_ram #(
    .DATAWIDTH(DATAWIDTH),
    .DEPTH    (DEPTH)
  ) u_ram (
    .clk_i    (clk_i),
    .rd_en_i  (acc),
    .rd_addr_i(PC_i[ADDRW+1:2]),
    .rd_data_o(rd_data),
    .wr_en_i  (wr_en_i),
    .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i)
  );

  always_comb begin
    oob     = (PC_i >> (ADDRW + 2)) != '0;
    acc_flt = classify(PC_i[1:0], oob);
    pop     = (cnt_q != 2'd0) && !stall_i;
    // Slot free now, or one frees this cycle; flush empties everything.
    ready_o = flush_i
           || ((cnt_q + {1'b0, infl_q}) < 2'd2)
           || pop;
    acc     = req_i && ready_o;

    push_ent.ins = (iflt_q == FAULT_NONE) ? rd_data : NOP_W;
    push_ent.pc  = ipc_q;
    push_ent.flt = iflt_q;

    fifo_d = fifo_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    infl_d = acc;
    ipc_d  = acc ? PC_i : ipc_q;
    iflt_d = acc ? acc_flt : iflt_q;

    if (flush_i) begin
      head_d = 1'b0;
      tail_d = 1'b0;
      cnt_d  = 2'd0;
    end else begin
      // Invariant count + inflight <= 2 guarantees room for the push.
      if (infl_q) begin
        fifo_d[tail_q] = push_ent;
        tail_d         = ~tail_q;
      end
      if (pop) head_d = ~head_q;
      cnt_d = cnt_q + {1'b0, infl_q} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fifo_q <= '0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      cnt_q  <= 2'd0;
      infl_q <= 1'b0;
      ipc_q  <= '0;
      iflt_q <= FAULT_NONE;
    end else begin
      fifo_q <= fifo_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      infl_q <= infl_d;
      ipc_q  <= ipc_d;
      iflt_q <= iflt_d;
    end
  end

  assign valid_o       = cnt_q != 2'd0;
  assign instruction_o = fifo_q[head_q].ins;
  assign PC_o          = fifo_q[head_q].pc;
  assign fault_o       = fifo_q[head_q].flt;

endmodule

// File: tb/tb_atomrvcore_imem_resp.sv
// Bench for atomrvcore_imem_resp: queue model + directed vectors.
// Model tracks accepted fetches in order with their accept edge.
module tb_atomrvcore_imem_resp;
  import atomrvcore_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic [31:0] PC_i = '0;
  logic        ready_o;
  logic        flush_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        valid_o;
  logic [31:0] instruction_o;
  logic [31:0] PC_o;
  fault_t      fault_o;
  logic        wr_en_i = 1'b0;
  logic [9:0]  wr_addr_i = '0;
  logic [31:0] wr_data_i = '0;

  always #5 clk_i = ~clk_i;

  atomrvcore_imem_resp dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .PC_i         (PC_i),
    .ready_o      (ready_o),
    .flush_i      (flush_i),
    .stall_i      (stall_i),
    .valid_o      (valid_o),
    .instruction_o(instruction_o),
    .PC_o         (PC_o),
    .fault_o      (fault_o),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [1:0]  f;
    int          e;
  } ment_t;

  ment_t       mq[$];
  ment_t       lg[$];
  logic [31:0] mem_m [1024];
  int          cyc = 0;

  initial begin
    bit          ev, er, pop, acc, we;
    logic [9:0]  wa;
    logic [31:0] wd;
    ment_t       ne;
    forever begin
      @(negedge clk_i);
      pop = 0;
      acc = 0;
      we  = wr_en_i;
      wa  = wr_addr_i;
      wd  = wr_data_i;
      if (rst_i) begin
        mq.delete();
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_ins", instruction_o, 32'd0);
        chk("rst_pc", PC_o, 32'd0);
      end else begin
        ev = 0;
        if (mq.size() > 0) ev = (cyc >= mq[0].e + 1);
        chk("valid", 32'(valid_o), 32'(ev));
        if (ev) begin
          chk("ins", instruction_o, mq[0].ins);
          chk("pc", PC_o, mq[0].pc);
          chk("fault", 32'(fault_o), 32'(mq[0].f));
        end
        er = flush_i || (mq.size() < 2) || (ev && !stall_i);
        chk("ready", 32'(ready_o), 32'(er));
        pop = ev && !stall_i;
        acc = req_i && er;
        if (valid_o && !stall_i) begin
          ne.ins = instruction_o;
          ne.pc  = PC_o;
          ne.f   = fault_o;
          ne.e   = cyc;
          lg.push_back(ne);
        end
        if (acc) begin
          ne.pc = PC_i;
          ne.e  = cyc + 1;
          if (PC_i[1:0] != 2'b00) ne.f = 2'd1;
          else if (PC_i >= 32'h1000) ne.f = 2'd2;
          else ne.f = 2'd0;
          ne.ins = (ne.f == 2'd0) ? mem_m[PC_i[11:2]] : 32'h13;
        end
      end
      @(posedge clk_i);
      cyc++;
      if (!rst_i) begin
        if (flush_i) mq.delete();
        else if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(ne);
      end
      if (we) mem_m[wa] = wd;
    end
  end

  task automatic issue(input logic [31:0] pc);
    bit ok = 0;
    req_i = 1'b1;
    PC_i  = pc;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk_i);
      ok = ready_o;
      @(posedge clk_i);
      #1;
    end
    req_i = 1'b0;
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL issue_timeout: pc %h never accepted", pc);
    end
  endtask

  task automatic drain();
    req_i = 1'b0;
    repeat (6) @(posedge clk_i);
    #1;
  endtask

  task automatic chk_log(input string nm, input int i,
                         input logic [31:0] ins, input logic [31:0] pc,
                         input logic [1:0] f);
    if (i < lg.size()) begin
      chk({nm, "_ins"}, lg[i].ins, ins);
      chk({nm, "_pc"}, lg[i].pc, pc);
      chk({nm, "_f"}, 32'(lg[i].f), 32'(f));
    end else begin
      chk({nm, "_size"}, lg.size(), i + 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    chk("init_valid", 32'(valid_o), 32'd0);
    chk("init_ins", instruction_o, 32'd0);
    rst_i = 1'b0;

    for (int i = 0; i < 16; i++) begin
      wr_en_i   = 1'b1;
      wr_addr_i = 10'(i);
      wr_data_i = 32'h100 + 32'(i);
      @(posedge clk_i);
      #1;
    end
    wr_en_i = 1'b0;

    // Stream 0..28 with a 3-cycle stall while PC 8 is at the head.
    lg.delete();
    fork
      for (int i = 0; i < 8; i++) issue(32'(i * 4));
      begin
        for (int t = 0; t < 40 && !(valid_o && PC_o == 32'd8); t++) begin
          @(posedge clk_i);
          #1;
        end
        stall_i = 1'b1;
        repeat (3) begin
          @(negedge clk_i);
          chk("hold_pc", PC_o, 32'd8);
          chk("hold_ins", instruction_o, 32'h102);
          @(posedge clk_i);
          #1;
        end
        stall_i = 1'b0;
      end
    join
    drain();
    chk("p1_count", lg.size(), 8);
    for (int i = 0; i < 8; i++)
      chk_log("p1", i, 32'h100 + 32'(i), 32'(i * 4), 2'd0);

    lg.delete();
    issue(32'h6);
    issue(32'h1000);
    drain();
    chk("p2_count", lg.size(), 2);
    chk_log("mis", 0, 32'h13, 32'h6, 2'd1);
    chk_log("oob", 1, 32'h13, 32'h1000, 2'd2);

    // Fill the FIFO under stall, then flush with a branch target.
    lg.delete();
    stall_i = 1'b1;
    issue(32'h0);
    issue(32'h4);
    @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    req_i   = 1'b1;
    PC_i    = 32'h20;
    @(negedge clk_i);
    chk("flush_ready", 32'(ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    req_i   = 1'b0;
    stall_i = 1'b0;
    drain();
    chk("p3_count", lg.size(), 1);
    chk_log("flush", 0, 32'h108, 32'h20, 2'd0);

    lg.delete();
    wr_en_i   = 1'b1;
    wr_addr_i = 10'd3;
    wr_data_i = 32'hDEAD_BEEF;
    issue(32'd12);
    wr_en_i = 1'b0;
    issue(32'd12);
    drain();
    chk("p4_count", lg.size(), 2);
    chk_log("rdfirst", 0, 32'h103, 32'd12, 2'd0);
    chk_log("rdnew", 1, 32'hDEAD_BEEF, 32'd12, 2'd0);

    // Asynchronous reset in the middle of a stream.
    req_i = 1'b1;
    PC_i  = 32'h0;
    repeat (4) @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    req_i = 1'b0;
    #1;
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_ins", instruction_o, 32'd0);
    chk("arst_pc", PC_o, 32'd0);
    chk("arst_fault", 32'(fault_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    chk("post_rst_ready", 32'(ready_o), 32'd1);
    lg.delete();
    issue(32'h4);
    @(negedge clk_i);
    chk("lat_inflight", 32'(valid_o), 32'd0);
    @(negedge clk_i);
    chk("lat_valid", 32'(valid_o), 32'd1);
    chk("lat_ins", instruction_o, 32'h101);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
